div_unit_32bit: RTL and testbench

//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). The decode/ALU side issues operands and

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_unit_32bit_cmp.sv | 29 ++
 rtl/div_unit_32bit.sv | 181 ++++++++++++++++++
 tb/tb_div_unit_32bit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the RV32M multi-cycle divider.
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int XLEN_DEF = 32;

    // Quotient returned for a divide-by-zero (all ones, i.e. -1 / 2^XLEN-1)
    localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;

    // Most negative signed value; INT_MIN / -1 overflows
    localparam logic [XLEN_DEF-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Per-operation control captured at accept time
    typedef struct packed {
        logic rem_sel;   // 1: return remainder
        logic q_neg;     // quotient must be negated at the end
        logic r_neg;     // remainder must be negated at the end
    } div_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/div_unit_32bit_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_32bit_cmp
//  Description : Magnitude comparator, signed or unsigned, o_less = (a < b).
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit_32bit_cmp #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic             o_less
);

    logic [WIDTH-1:0] w_a_biased;
    logic [WIDTH-1:0] w_b_biased;

    // Flipping the sign bits turns a two's complement compare into an unsigned one
    always_comb begin
        w_a_biased            = i_a;
        w_b_biased            = i_b;
        w_a_biased[WIDTH-1]   = i_a[WIDTH-1] ^ i_signed;
        w_b_biased[WIDTH-1]   = i_b[WIDTH-1] ^ i_signed;
        o_less                = (w_a_biased < w_b_biased);
    end

endmodule
`default_nettype wire

// File: rtl/div_unit_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_32bit
//  Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Radix-2
//                restoring division on magnitudes, one quotient bit per
//                cycle, followed by a sign fix-up cycle. Divide-by-zero and
//                signed overflow bypass the iteration loop.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit_32bit
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_signed,
    input  logic            i_rem,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int ITER_W = $clog2(XLEN);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(XLEN - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    div_state_e        state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              result_load;

    // Datapath registers (not reset: always written on accept before use)
    logic [XLEN-1:0]   dvd_q;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   rem_q;       // partial remainder
    logic [XLEN-1:0]   divisor_q;   // divisor magnitude
    div_ctrl_t         ctrl_q;

    // ------------------------------------------------------------------------
    // Accept-side decode
    // ------------------------------------------------------------------------
    logic            w_accept;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div0, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept  = i_valid && (state_q == IDLE);
    assign w_a_neg   = i_signed & i_operand_a[XLEN-1];
    assign w_b_neg   = i_signed & i_operand_b[XLEN-1];
    assign w_a_mag   = w_a_neg ? -i_operand_a : i_operand_a;
    assign w_b_mag   = w_b_neg ? -i_operand_b : i_operand_b;
    assign w_div0    = (i_operand_b == '0);
    assign w_ovf     = i_signed && (i_operand_a == INT_MIN) && (i_operand_b == '1);
    assign w_special = w_div0 | w_ovf;

    // Results that need no iteration: x/0 and INT_MIN/-1
    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = i_rem ? i_operand_a : DIV0_QUOT;
        end else begin
            w_special_res = i_rem ? '0 : INT_MIN;
        end
    end

    // ------------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------------
    logic [XLEN:0]   w_rem_shift;   // XLEN+1 wide so the shifted-out bit is kept
    logic [XLEN-1:0] w_rem_sub;
    logic            w_less;
    logic            w_ge;

    assign w_rem_shift = {rem_q, dvd_q[XLEN-1]};

    div_unit_32bit_cmp #(
        .WIDTH (XLEN + 1)
    ) u_cmp (
        .i_a      (w_rem_shift),
        .i_b      ({1'b0, divisor_q}),
        .i_signed (1'b0),
        .o_less   (w_less)
    );

    assign w_ge = ~w_less;

    // When w_ge holds the true difference is below the divisor, so the low
    // XLEN bits of the subtraction are exact.
    assign w_rem_sub = w_rem_shift[XLEN-1:0] - divisor_q;

    // Sign fix-up of the finished quotient/remainder
    logic [XLEN-1:0] w_q_fix, w_r_fix;
    assign w_q_fix = ctrl_q.q_neg ? -dvd_q : dvd_q;
    assign w_r_fix = ctrl_q.r_neg ? -rem_q : rem_q;

    // ------------------------------------------------------------------------
    // Next-state, counter, result load and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_load = 1'b0;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (w_accept) begin
                    cnt_d = '0;
                    if (w_special) begin
                        state_d     = DONE;
                        result_d    = w_special_res;
                        result_load = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d     = DONE;
                result_d    = ctrl_q.rem_sel ? w_r_fix : w_q_fix;
                result_load = 1'b1;
            end
            DONE: begin
                o_valid = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, iteration counter and output result register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (result_load) begin
                result_q <= result_d;
            end
        end
    end

    // Operand capture on accept, then one restoring step per CALC cycle
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            dvd_q          <= w_a_mag;
            divisor_q      <= w_b_mag;
            rem_q          <= '0;
            ctrl_q.rem_sel <= i_rem;
            ctrl_q.q_neg   <= w_a_neg ^ w_b_neg;
            ctrl_q.r_neg   <= w_a_neg;
        end else if (state_q == CALC) begin
            dvd_q <= {dvd_q[XLEN-2:0], w_ge};
            rem_q <= w_ge ? w_rem_sub : w_rem_shift[XLEN-1:0];
        end
    end

    assign o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit_32bit
//  Description : Directed self-checking bench for div_unit_32bit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] opa, opb;
    logic        sgn, remsel;
    logic        valid_out;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit_32bit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid_in),
        .o_ready     (ready_out),
        .i_operand_a (opa),
        .i_operand_b (opb),
        .i_signed    (sgn),
        .i_rem       (remsel),
        .o_valid     (valid_out),
        .o_result    (result)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present a request in the current cycle; accepted at the next rising edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
        @(negedge clk);
        opa      = a;
        opb      = b;
        sgn      = s;
        remsel   = r;
        valid_in = 1'b1;
    endtask

    // Run one operation and check latency, result, pulse width and result hold
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic r, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(a, b, s, r);
        check_value({tag, " ready"}, {31'd0, ready_out}, 32'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            valid_in = 1'b0;
            lat++;
        end while (!valid_out && lat < 100);
        check_value({tag, " latency"}, lat, exp_lat);
        check_value({tag, " result"}, result, exp);
        @(negedge clk);
        check_value({tag, " pulse"}, {31'd0, valid_out}, 32'd0);
        check_value({tag, " hold"}, result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst      = 1'b1;
        valid_in = 1'b0;
        opa      = '0;
        opb      = '0;
        sgn      = 1'b0;
        remsel   = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset ready",  {31'd0, ready_out}, 32'd1);
        check_value("reset valid",  {31'd0, valid_out}, 32'd0);
        check_value("reset result", result, 32'd0);
        rst = 1'b0;

        // Unsigned and signed normal cases
        run_op("divu 100/7",   32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        34);
        run_op("remu 100/7",   32'd100,       32'd7,         1'b0, 1'b1, 32'd2,         34);
        run_op("div -7/2",     32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFD, 34);
        run_op("rem -7/2",     32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 32'hFFFF_FFFF, 34);
        run_op("div 7/-2",     32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 34);
        run_op("rem 7/-2",     32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1,         34);
        run_op("divu fff9/2",  32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 32'h7FFF_FFFC, 34);
        run_op("remu fff9/2",  32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1, 32'd1,         34);

        // Divide by zero
        run_op("div x/0",      32'h1234_5678, 32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF, 1);
        run_op("divu x/0",     32'h1234_5678, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 1);
        run_op("rem x/0",      32'h1234_5678, 32'd0,         1'b1, 1'b1, 32'h1234_5678, 1);
        run_op("remu x/0",     32'h1234_5678, 32'd0,         1'b0, 1'b1, 32'h1234_5678, 1);
        run_op("rem neg/0",    32'hFFFF_FFF9, 32'd0,         1'b1, 1'b1, 32'hFFFF_FFF9, 1);

        // Signed overflow, and the same operands unsigned (not special)
        run_op("div ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1);
        run_op("rem ovf",      32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0,         1);
        run_op("divu min/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,         34);
        run_op("remu min/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 34);

        // Reset in the middle of an operation
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(negedge clk);
        check_value("midrst ready",  {31'd0, ready_out}, 32'd1);
        check_value("midrst valid",  {31'd0, valid_out}, 32'd0);
        check_value("midrst result", result, 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check_value("midrst no pulse", seen, 0);
        run_op("divu 9/3 after rst", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 34);

        // Input activity during an operation is ignored
        issue(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k < 34) begin
                valid_in = 1'($urandom);
                opa      = $urandom;
                opb      = $urandom;
                sgn      = 1'($urandom);
                remsel   = 1'($urandom);
            end else begin
                valid_in = 1'b0;
            end
            check_value($sformatf("busy ready c%0d", k), {31'd0, ready_out}, 32'd0);
            if (k < 34) begin
                check_value($sformatf("busy valid c%0d", k), {31'd0, valid_out}, 32'd0);
            end else begin
                check_value("busy valid final", {31'd0, valid_out}, 32'd1);
                check_value("busy result", result, 32'h0FFF_FFFF);
            end
        end
        @(negedge clk);
        check_value("busy back idle", {31'd0, ready_out}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
